sipo_frame_ctrl: RTL and testbench

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

---
 rtl/sipo_frame_ctrl.sv | 105 ++++++++++
 tb/tb_sipo_frame_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame receiver: collects WIDTH bits LSB-first after a
// start strobe and hands the word to a ready/valid consumer, flagging dropped words.
module sipo_frame_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             abort,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sr, sr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] dout_d;
  logic             dv_d;
  logic             ovr_d;
  logic [WIDTH-1:0] word;

  // New bit enters at the MSB so after WIDTH shifts the first bit sits at bit 0.
  assign word = {serial_in, sr[WIDTH-1:1]};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    dout_d  = data_out;
    dv_d    = data_valid;
    ovr_d   = overrun;

    if (data_valid && data_ready) dv_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          sr_d    = '0;
          cnt_d   = '0;
        end else if (bit_valid) begin
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state_d = IDLE;
            sr_d    = '0;
            cnt_d   = '0;
            // A consumer taking the old word this cycle frees the holding register.
            if (!data_valid || data_ready) begin
              dout_d = word;
              dv_d   = 1'b1;
            end else begin
              ovr_d  = 1'b1;
            end
          end else begin
            sr_d  = word;
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      sr         <= sr_d;
      cnt        <= cnt_d;
      data_out   <= dout_d;
      data_valid <= dv_d;
      overrun    <= ovr_d;
    end
  end

  assign busy    = (state == SHIFT);
  assign bit_cnt = cnt;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: directed frames with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_sipo_frame_ctrl;

  localparam int W     = 8;
  localparam int CNT_W = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             start, bit_valid, serial_in, abort, data_ready;
  logic [W-1:0]     data_out;
  logic             data_valid, busy, overrun;
  logic [CNT_W-1:0] bit_cnt;

  int tests = 0;
  int fails = 0;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bit_valid  (bit_valid),
    .serial_in  (serial_in),
    .abort      (abort),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is a count of bits received and their arithmetic
  // value (bit i weighs 2**i); the consumer side is a one-word holding slot.
  bit       m_in_frame;
  int       m_nbits;
  int       m_acc;
  bit [W-1:0] m_dout;
  bit       m_dv;
  bit       m_ovr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_in_frame = 0; m_nbits = 0; m_acc = 0;
      m_dout = '0; m_dv = 0; m_ovr = 0;
    end else begin
      bit old_dv;
      bit new_dv;
      old_dv = m_dv;
      new_dv = old_dv && !data_ready;
      if (!m_in_frame) begin
        if (start) begin
          m_in_frame = 1; m_nbits = 0; m_acc = 0;
        end
      end else if (abort) begin
        m_in_frame = 0; m_nbits = 0; m_acc = 0;
      end else if (bit_valid) begin
        m_acc   = m_acc + (int'(serial_in) << m_nbits);
        m_nbits = m_nbits + 1;
        if (m_nbits == W) begin
          if (!old_dv || data_ready) begin
            m_dout = W'(m_acc);
            new_dv = 1;
          end else begin
            m_ovr = 1;
          end
          m_in_frame = 0; m_nbits = 0; m_acc = 0;
        end
      end
      m_dv = new_dv;
    end
  end

  // Single compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    check("cmp_data_out",   32'(data_out),   32'(m_dout));
    check("cmp_data_valid", 32'(data_valid), 32'(m_dv));
    check("cmp_busy",       32'(busy),       32'(m_in_frame));
    check("cmp_bit_cnt",    32'(bit_cnt),    32'(m_nbits));
    check("cmp_overrun",    32'(overrun),    32'(m_ovr));
  end

  // Drive one cycle of inputs, then land 1 time unit after the next rising edge.
  task automatic cyc(input bit s, input bit bv, input bit si, input bit ab, input bit rd);
    start = s; bit_valid = bv; serial_in = si; abort = ab; data_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input bit rd);
    cyc(0, 0, 0, 0, rd);
  endtask

  // Full frame; data_ready is held at rd except last_rd on the final bit.
  // A gap of gap_len idle cycles is inserted after gap_after bits.
  task automatic frame(input logic [W-1:0] w, input bit rd, input bit last_rd,
                       input int gap_after, input int gap_len);
    cyc(1, 1, ~w[0], 0, rd);  // bit_valid in the start cycle must be ignored
    for (int i = 0; i < W; i++) begin
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          cyc(0, 0, 1, 0, rd);
          check("gap_bit_cnt", 32'(bit_cnt), 32'(gap_after));
        end
      end
      cyc(0, 1, w[i], 0, (i == W - 1) ? last_rd : rd);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    idle_cyc(0);
    reset = 0;
    idle_cyc(0);
  endtask

  initial begin
    reset = 1; start = 0; bit_valid = 0; serial_in = 0; abort = 0; data_ready = 0;
    #1;
    check("rst_data_out",   32'(data_out),   32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    check("rst_overrun",    32'(overrun),    32'h0);
    @(posedge clk); #1;
    reset = 0;
    idle_cyc(0);

    // Basic 0xA5 frame, result visible on the edge after the 8th bit.
    frame(8'hA5, 0, 0, -1, 0);
    check("a5_data_out",   32'(data_out),   32'hA5);
    check("a5_data_valid", 32'(data_valid), 32'h1);
    check("a5_busy",       32'(busy),       32'h0);
    check("a5_bit_cnt",    32'(bit_cnt),    32'h0);
    idle_cyc(1);
    check("a5_consumed", 32'(data_valid), 32'h0);

    // Same frame with a 3-cycle bit_valid gap after bit 4.
    frame(8'hA5, 0, 0, 4, 3);
    check("gap_data_out", 32'(data_out), 32'hA5);
    idle_cyc(1);

    // Overrun: second word dropped while the first is unconsumed.
    frame(8'hA5, 0, 0, -1, 0);
    frame(8'h3C, 0, 0, -1, 0);
    check("ovr_data_out", 32'(data_out), 32'hA5);
    check("ovr_overrun",  32'(overrun),  32'h1);
    idle_cyc(1);
    check("ovr_dv_clear", 32'(data_valid), 32'h0);
    idle_cyc(0);
    check("ovr_sticky", 32'(overrun), 32'h1);

    // Consume and complete in the same cycle: new word replaces the old one.
    do_reset();
    frame(8'hA5, 0, 0, -1, 0);
    frame(8'h3C, 0, 1, -1, 0);
    check("swap_data_out",   32'(data_out),   32'h3C);
    check("swap_data_valid", 32'(data_valid), 32'h1);
    check("swap_overrun",    32'(overrun),    32'h0);

    // Abort after 5 bits, data_valid left untouched.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);
    check("abort_pre_cnt", 32'(bit_cnt), 32'h5);
    cyc(0, 1, 1, 1, 0);
    check("abort_busy",    32'(busy),       32'h0);
    check("abort_bit_cnt", 32'(bit_cnt),    32'h0);
    check("abort_dv",      32'(data_valid), 32'h1);
    check("abort_dout",    32'(data_out),   32'h3C);
    idle_cyc(1);
    frame(8'h0F, 0, 0, -1, 0);
    check("post_abort_dout", 32'(data_out), 32'h0F);
    idle_cyc(1);

    // Asynchronous reset mid-frame, between clock edges.
    frame(8'h55, 0, 0, -1, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
    #2 reset = 1;
    #1;
    check("arst_data_out", 32'(data_out),   32'h0);
    check("arst_dv",       32'(data_valid), 32'h0);
    check("arst_busy",     32'(busy),       32'h0);
    check("arst_bit_cnt",  32'(bit_cnt),    32'h0);
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 10; i++) cyc(0, 1, 1'($urandom), 0, 0);
    check("arst_no_word", 32'(data_valid), 32'h0);
    check("arst_no_busy", 32'(busy),       32'h0);

    // Randomized traffic, checked by the compare process.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 599) == 0);
      cyc($urandom_range(0, 7) == 0,
          $urandom_range(0, 3) != 0,
          1'($urandom),
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 2) == 0);
    end
    reset = 0;
    idle_cyc(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
